// File: rtl/snake_pkg.sv
// Shared types for the game-screen renderer: tile kinds, the packed tile
// record handed from the fetch stage to the drawing stage, default map
// geometry and the fetch latency helper.
package snake_pkg;

    // Tile contents stored in the map RAM. The encoding is 4 bits wide so
    // that corrupt RAM words (8..15) can be recognised and suppressed.
    typedef enum logic [3:0] {
        T_VOID    = 4'd0,
        T_EMPTY   = 4'd1,
        T_WALL    = 4'd2,
        T_FOOD    = 4'd3,
        T_S1_HEAD = 4'd4,
        T_S1_BODY = 4'd5,
        T_S2_HEAD = 4'd6,
        T_S2_BODY = 4'd7
    } tile_kind;

    // Tile kind plus the pixel offsets inside the tile.
    typedef struct packed {
        tile_kind    kind;
        logic [5:0]  px;
        logic [5:0]  py;
    } tile;

    // Last legal kind; anything above it never renders.
    localparam logic [3:0] KIND_LAST = 4'd7;

    // Default screen/map geometry (640x480 screen, 16-pixel tiles).
    localparam int DEF_TILE_SIZE = 16;
    localparam int DEF_MAP_W     = 40;
    localparam int DEF_MAP_H     = 30;
    localparam int COORD_W       = 12;

    // Blank tile driven whenever the pixel is outside the map.
    localparam tile TILE_VOID = '{kind: T_VOID, px: 6'd0, py: 6'd0};

    // Cycles from hcount/vcount to act_tile for a given RAM read latency:
    // S1 register, S2 address register, the RAM itself, output register.
    function automatic int fetch_lat(input int mem_lat);
        return 3 + mem_lat;
    endfunction

    // True when a raw RAM word is one of the enumerated kinds.
    function automatic logic kind_valid(input logic [3:0] raw);
        return (raw <= KIND_LAST) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/tile_delay.sv
// Fixed-depth shift register that carries the pipeline's side-band bits
// (in_map flag, in-tile offsets) alongside the map RAM read.
module tile_delay #(
    parameter int N = 1,
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [N];

    // Shift the side-band word one stage per cycle; reset flushes every stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= {W{1'b0}};
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < N; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[N-1];

endmodule

// File: rtl/map_tile_fetch.sv
// Upstream stage of the game-screen renderer. Maps the VGA pixel position to
// a tile coordinate, reads the tile kind from the map RAM and presents it to
// the drawing stage with a constant latency of fetch_lat(MEM_LAT) cycles.
// Also produces the once-per-frame map update window pulse.
module map_tile_fetch
    import snake_pkg::*;
#(
    parameter int TILE_SIZE = DEF_TILE_SIZE,
    parameter int MAP_W     = DEF_MAP_W,
    parameter int MAP_H     = DEF_MAP_H,
    parameter int ORIGIN_X  = 0,
    parameter int ORIGIN_Y  = 0,
    parameter int MEM_LAT   = 1,
    localparam int ADDR_W   = $clog2(MAP_W * MAP_H),
    localparam int KIND_W   = $bits(tile_kind)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        hcount,
    input  logic [11:0]        vcount,
    input  logic               hblnk,
    input  logic               vblnk,
    output logic               map_rd_en,
    output logic [ADDR_W-1:0]  map_addr,
    input  logic [KIND_W-1:0]  map_data,
    output tile                act_tile,
    output logic               frame_upd
);

    localparam int TILE_LOG2 = $clog2(TILE_SIZE);
    localparam int SIDE_W    = 13;

    // Map window in screen pixels, [LO, HI).
    localparam logic [31:0] X_LO = 32'(ORIGIN_X);
    localparam logic [31:0] X_HI = 32'(ORIGIN_X + MAP_W * TILE_SIZE);
    localparam logic [31:0] Y_LO = 32'(ORIGIN_Y);
    localparam logic [31:0] Y_HI = 32'(ORIGIN_Y + MAP_H * TILE_SIZE);

    localparam logic [11:0] ORG_X12 = 12'(ORIGIN_X);
    localparam logic [11:0] ORG_Y12 = 12'(ORIGIN_Y);
    localparam logic [11:0] PX_MASK = 12'(TILE_SIZE - 1);

    // ---------------- S1: map-relative coordinates ----------------
    logic [11:0] rx_d, rx_q;
    logic [11:0] ry_d, ry_q;
    logic        in_map1_d, in_map1_q;

    // ---------------- S2: RAM address and tile offsets -------------
    logic [11:0]       tx_s, ty_s;
    logic [ADDR_W-1:0] map_addr_d, map_addr_q;
    logic              map_rd_en_d, map_rd_en_q;
    logic [5:0]        px2_d, px2_q;
    logic [5:0]        py2_d, py2_q;

    // ---------------- S3..: side-band across RAM latency -----------
    logic [SIDE_W-1:0] side_in_s;
    logic [SIDE_W-1:0] side_out_s;
    logic              dly_in_map_s;
    logic [5:0]        dly_px_s;
    logic [5:0]        dly_py_s;

    // ---------------- Output and frame pulse ----------------------
    tile  act_tile_d, act_tile_q;
    logic frame_upd_d, frame_upd_q;
    logic vblnk_hist_q;

    // S1 next state: offset the pixel position by the map origin and decide
    // whether it lies inside the map. A pixel left of / above the origin wraps
    // to a large rx/ry, so the origin comparison on the raw count rejects it.
    always_comb begin
        rx_d      = hcount - ORG_X12;
        ry_d      = vcount - ORG_Y12;
        in_map1_d = 1'b0;
        if (!hblnk && !vblnk &&
            (32'(hcount) >= X_LO) && (32'(hcount) < X_HI) &&
            (32'(vcount) >= Y_LO) && (32'(vcount) < Y_HI)) begin
            in_map1_d = 1'b1;
        end else begin
            in_map1_d = 1'b0;
        end
    end

    // S1 register stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_q      <= 12'd0;
            ry_q      <= 12'd0;
            in_map1_q <= 1'b0;
        end else begin
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            in_map1_q <= in_map1_d;
        end
    end

    // S2 next state: split into tile index and in-tile offset, then form the
    // row-major RAM address. The address only moves for in-map pixels so the
    // RAM sees no spurious address toggling during blanking.
    always_comb begin
        tx_s        = rx_q >> TILE_LOG2;
        ty_s        = ry_q >> TILE_LOG2;
        px2_d       = 6'(rx_q & PX_MASK);
        py2_d       = 6'(ry_q & PX_MASK);
        map_rd_en_d = in_map1_q;
        map_addr_d  = map_addr_q;
        if (in_map1_q) begin
            map_addr_d = ADDR_W'(32'(ty_s) * 32'(MAP_W) + 32'(tx_s));
        end else begin
            map_addr_d = map_addr_q;
        end
    end

    // S2 register stage; map_rd_en doubles as the in_map flag of this stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            map_addr_q  <= {ADDR_W{1'b0}};
            map_rd_en_q <= 1'b0;
            px2_q       <= 6'd0;
            py2_q       <= 6'd0;
        end else begin
            map_addr_q  <= map_addr_d;
            map_rd_en_q <= map_rd_en_d;
            px2_q       <= px2_d;
            py2_q       <= py2_d;
        end
    end

    assign side_in_s = {map_rd_en_q, px2_q, py2_q};

    tile_delay #(
        .N (MEM_LAT),
        .W (SIDE_W)
    ) u_tile_delay (
        .clk (clk),
        .rst (rst),
        .d   (side_in_s),
        .q   (side_out_s)
    );

    assign {dly_in_map_s, dly_px_s, dly_py_s} = side_out_s;

    // Output next state: accept the RAM word only for in-map pixels holding
    // a legal kind; everything else collapses to a blank tile with zero offsets.
    always_comb begin
        act_tile_d = TILE_VOID;
        if (dly_in_map_s && kind_valid(map_data)) begin
            act_tile_d.kind = tile_kind'(map_data);
            act_tile_d.px   = dly_px_s;
            act_tile_d.py   = dly_py_s;
        end else begin
            act_tile_d = TILE_VOID;
        end
    end

    // Output register towards the drawing stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            act_tile_q <= TILE_VOID;
        end else begin
            act_tile_q <= act_tile_d;
        end
    end

    // Frame pulse next state: rising edge of vertical blanking.
    always_comb begin
        frame_upd_d = 1'b0;
        if (vblnk && !vblnk_hist_q) begin
            frame_upd_d = 1'b1;
        end else begin
            frame_upd_d = 1'b0;
        end
    end

    // Frame pulse register; history resets high so no pulse follows reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_upd_q  <= 1'b0;
            vblnk_hist_q <= 1'b1;
        end else begin
            frame_upd_q  <= frame_upd_d;
            vblnk_hist_q <= vblnk;
        end
    end

    assign map_rd_en = map_rd_en_q;
    assign map_addr  = map_addr_q;
    assign act_tile  = act_tile_q;
    assign frame_upd = frame_upd_q;

endmodule

// File: doc/map_tile_fetch.md
Name: map_tile_fetch

Overview:
- Upstream stage of the game-screen renderer.
- Converts the VGA pixel position into a map-tile coordinate and reads that tile's content from the game map RAM through a synchronous read port.
- Drives the act_tile consumed by the drawing stage, with a fixed, documented latency. The drawing stage adds this latency to its own delay-matching budget.
- Also emits a once-per-frame update-window pulse so game logic writes the map RAM only outside the active area.

Parameters:
- TILE_SIZE, 16, tile edge in pixels; power of two, 4..64.
- MAP_W, 40, map width in tiles.
- MAP_H, 30, map height in tiles.
- ORIGIN_X, 0, pixel x of the map's left edge.
- ORIGIN_Y, 0, pixel y of the map's top edge.
- MEM_LAT, 1, map RAM read latency in cycles (1..2).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-low reset
- hcount  in  12  current pixel x
- vcount  in  12  current pixel y
- hblnk  in  1  horizontal blanking
- vblnk  in  1  vertical blanking
- map_rd_en  out  1  RAM read enable
- map_addr  out  $clog2(MAP_W*MAP_H)  RAM address, ty*MAP_W+tx
- map_data  in  $bits(tile_kind)  RAM data, valid MEM_LAT cycles after map_rd_en
- act_tile  out  $bits(tile)  tile kind plus in-tile pixel offsets px, py
- frame_upd  out  1  one-cycle pulse at the start of vertical blanking

Behaviour:
- Reset (rst==0 at posedge): all pipeline valid bits cleared, map_rd_en=0, map_addr=0, act_tile='{kind:T_VOID, px:0, py:0}, frame_upd=0, vblnk history=1 (so a frame_upd pulse cannot fire on the first cycle after reset).
- Pipeline, one register per stage:
  - S1: rx=hcount-ORIGIN_X, ry=vcount-ORIGIN_Y, 12-bit. in_map = !hblnk && !vblnk && hcount>=ORIGIN_X && hcount<ORIGIN_X+MAP_W*TILE_SIZE, and the same test in y.
  - S2: tx=rx>>log2(TILE_SIZE), ty likewise; px=rx[log2-1:0], py likewise. map_addr=ty*MAP_W+tx, using constant multiply, no DSP requirement. map_rd_en=in_map. When !in_map, map_addr holds its previous value.
  - S3..S(2+MEM_LAT): in_map, px and py are delayed alongside the RAM read.
  - Output register: act_tile.kind = map_data if delayed in_map, else T_VOID. px and py are forced to 0 when T_VOID.
- Latency FETCH_LAT = 3+MEM_LAT cycles from hcount/vcount to act_tile, constant for every pixel including blanking.
  - Exported as a package function fetch_lat(MEM_LAT) so the drawing stage can size its delay.
- map_data values above the last enumerated kind are mapped to T_VOID, so corrupt RAM never renders.
- Edge cases:
  - Negative rx/ry (wrap in 12 bits) is caught by the comparison against ORIGIN, never by the range check on rx.
  - The last pixel column or row of the map is inside; the next one is T_VOID.
  - A tile boundary crossing mid-line produces a new address on the very next cycle; there is no caching or skipping.
- frame_upd: registered rising-edge detect on vblnk; high for exactly one cycle per frame. It is independent of the pipeline, so it is not delayed by FETCH_LAT.
- Reset asserted mid-line: the pipeline flushes immediately. Output is T_VOID for FETCH_LAT cycles after release, then valid data resumes.

Decomposition:
- snake_pkg: typedef enum tile_kind {T_VOID, T_EMPTY, T_WALL, T_FOOD, T_S1_HEAD, T_S1_BODY, T_S2_HEAD, T_S2_BODY}.
- snake_pkg: typedef struct packed tile {kind; px[5:0]; py[5:0]}.
- snake_pkg: localparams for default map size, and function fetch_lat.
- One natural sub-module, tile_delay: a parameterised shift register of depth N and width W that carries in_map, px and py across the RAM latency.

Test Plan:
- Reset held 5 cycles during active video -> act_tile.kind==T_VOID, map_rd_en==0, frame_upd==0. After release, the first valid tile appears exactly 4 cycles (MEM_LAT=1) after the first in-map hcount.
- hcount=0..47, vcount=0, RAM model returns kind=addr[2:0] -> map_addr steps 0,1,2 every 16 pixels; px counts 0..15 and repeats; act_tile lags hcount by 4 cycles.
- Pixel (639,479), MAP 40x30, TILE 16 -> map_addr=1199, px=py=15. Pixel hcount=640 -> T_VOID, map_rd_en=0.
- ORIGIN_X=32, hcount=31/32 -> T_VOID, then tile tx=0; hcount=0 (rx wraps to 4064) -> T_VOID.
- vblnk 0->1 -> frame_upd high exactly 1 cycle; vblnk held high 45 lines -> no further pulse.
- MEM_LAT=2 rebuild -> total latency 5 cycles; map_data=4'hF (out of range) -> T_VOID.
